// File: rtl/hazard_pkg.sv
// Shared types and forwarding-select encodings for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } hz_state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one E-stage source register; M result beats W result.
import hazard_pkg::*;

module hazard_fwd_sel #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rd_m,
  input  logic [WIDTH-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       fwd
);

  // x0 is hardwired to zero, so a pending write to it must never be forwarded.
  always_comb begin
    fwd = FWD_NONE;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forwarding and memory-wait sequencing.
// Define HAZARD_PERF_EN to build the stall/flush/timeout performance counters.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 64,
  parameter int WIDTH            = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Rs1D,
  input  logic [WIDTH-1:0] Rs2D,
  input  logic [WIDTH-1:0] Rs1E,
  input  logic [WIDTH-1:0] Rs2E,
  input  logic [WIDTH-1:0] RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] RdM,
  input  logic [WIDTH-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             memReqM,
  input  logic             memAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             memTimeout,
  output logic [31:0]      perfStall,
  output logic [31:0]      perfFlush,
  output logic [31:0]      perfTimeout
);

  localparam int         TW     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [1:0] LU_CNT = 2'(LOAD_USE_BUBBLES - 1);

  hz_state_t      state, state_nxt;
  hz_state_t      ret_state, ret_nxt;
  logic [1:0]     cnt, cnt_nxt;
  logic [TW-1:0]  timer, timer_nxt;

  logic           load_use;
  logic           mem_stall;
  logic           timeout_hit;
  logic           stall_f, stall_d, stall_e, stall_m;
  logic           flush_d, flush_e, mem_to;
  logic [1:0]     fwd_a, fwd_b;

  hazard_fwd_sel #(.WIDTH(WIDTH)) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  hazard_fwd_sel #(.WIDTH(WIDTH)) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  assign load_use    = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall   = memReqM && !memAckM;
  assign timeout_hit = (timer == TW'(MEM_TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    cnt_nxt   = cnt;
    timer_nxt = timer;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    mem_to    = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'hf;
          ret_nxt   = RUN;
          timer_nxt = TW'(1);
          state_nxt = MEM_WAIT;
        end else if (PCSrcE) begin
          // A load-use seen alongside a redirect belongs to the wrong path.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (LOAD_USE_BUBBLES > 1) begin
            cnt_nxt   = LU_CNT;
            state_nxt = LU_STALL;
          end
        end
      end

      LU_STALL: begin
        if (mem_stall) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'hf;
          ret_nxt   = LU_STALL;
          timer_nxt = TW'(1);
          state_nxt = MEM_WAIT;
        end else begin
          // E holds a bubble, so a redirect cannot originate there.
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = RUN;
        end
      end

      MEM_WAIT: begin
        if (memAckM) begin
          timer_nxt = '0;
          state_nxt = ret_state;
        end else if (timeout_hit) begin
          mem_to    = 1'b1;
          flush_e   = 1'b1;
          cnt_nxt   = '0;
          timer_nxt = '0;
          state_nxt = RUN;
        end else begin
          {stall_f, stall_d, stall_e, stall_m} = 4'hf;
          timer_nxt = timer + TW'(1);
        end
      end

      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      cnt       <= cnt_nxt;
      timer     <= timer_nxt;
    end
  end

  // Reset squashes both front registers immediately, independent of the clock.
  assign StallF     = rst_n & stall_f;
  assign StallD     = rst_n & stall_d;
  assign StallE     = rst_n & stall_e;
  assign StallM     = rst_n & stall_m;
  assign FlushD     = !rst_n | flush_d;
  assign FlushE     = !rst_n | flush_e;
  assign ForwardAE  = rst_n ? fwd_a : FWD_NONE;
  assign ForwardBE  = rst_n ? fwd_b : FWD_NONE;
  assign memTimeout = rst_n & mem_to;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
      perf_timeout_q <= '0;
    end else begin
      if (StallF)           perf_stall_q   <= perf_stall_q + 32'd1;
      if (FlushD || FlushE) perf_flush_q   <= perf_flush_q + 32'd1;
      if (memTimeout)       perf_timeout_q <= perf_timeout_q + 32'd1;
    end
  end

  assign perfStall   = perf_stall_q;
  assign perfFlush   = perf_flush_q;
  assign perfTimeout = perf_timeout_q;
`else
  assign perfStall   = '0;
  assign perfFlush   = '0;
  assign perfTimeout = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (1 and 2 load-use bubbles) against a behavioural model.
module tb_hazard_ctrl;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic         mem_read_e, pc_src, rw_m, rw_w, mem_req, mem_ack;

  logic [1:0]   stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_to;
  logic [1:0]   fwd_a [2];
  logic [1:0]   fwd_b [2];
  logic [31:0]  perf_s [2];
  logic [31:0]  perf_f [2];
  logic [31:0]  perf_t [2];

  hazard_ctrl #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(8), .WIDTH(W)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e),
    .MemReadE(mem_read_e), .PCSrcE(pc_src), .RdM(rd_m), .RdW(rd_w),
    .RegWriteM(rw_m), .RegWriteW(rw_w), .memReqM(mem_req), .memAckM(mem_ack),
    .StallF(stall_f[0]), .StallD(stall_d[0]), .StallE(stall_e[0]), .StallM(stall_m[0]),
    .FlushD(flush_d[0]), .FlushE(flush_e[0]), .ForwardAE(fwd_a[0]), .ForwardBE(fwd_b[0]),
    .memTimeout(mem_to[0]), .perfStall(perf_s[0]), .perfFlush(perf_f[0]), .perfTimeout(perf_t[0])
  );

  hazard_ctrl #(.LOAD_USE_BUBBLES(2), .MEM_TIMEOUT(5), .WIDTH(W)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .Rs1E(rs1_e), .Rs2E(rs2_e), .RdE(rd_e),
    .MemReadE(mem_read_e), .PCSrcE(pc_src), .RdM(rd_m), .RdW(rd_w),
    .RegWriteM(rw_m), .RegWriteW(rw_w), .memReqM(mem_req), .memAckM(mem_ack),
    .StallF(stall_f[1]), .StallD(stall_d[1]), .StallE(stall_e[1]), .StallM(stall_m[1]),
    .FlushD(flush_d[1]), .FlushE(flush_e[1]), .ForwardAE(fwd_a[1]), .ForwardBE(fwd_b[1]),
    .memTimeout(mem_to[1]), .perfStall(perf_s[1]), .perfFlush(perf_f[1]), .perfTimeout(perf_t[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state per instance: bubbles still owed, whether a memory wait is open,
  // how many stall cycles that wait has produced, and the event tallies.
  int          lub [2] = '{1, 2};
  int          tmo [2] = '{8, 5};
  int          bub_left [2];
  bit          waiting [2];
  int          stalled [2];
  logic [31:0] m_s [2];
  logic [31:0] m_f [2];
  logic [31:0] m_t [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Output vector layout: SF SD SE SM FD FE FA[1:0] FB[1:0] TO
  function automatic logic [10:0] pack(input int i);
    return {stall_f[i], stall_d[i], stall_e[i], stall_m[i], flush_d[i], flush_e[i],
            fwd_a[i], fwd_b[i], mem_to[i]};
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [W-1:0] rs);
    if (rw_m && rd_m != 0 && rd_m == rs) return 2'd2;
    if (rw_w && rd_w != 0 && rd_w == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_step(input int i, input bit commit, output logic [10:0] o);
    logic sf, sd, se, sm, fd, fe, to;
    logic [1:0] fa, fb;
    bit lu;
    {sf, sd, se, sm, fd, fe, to} = '0;
    fa = 2'd0;
    fb = 2'd0;
    lu = mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (!rst_n) begin
      fd = 1'b1;
      fe = 1'b1;
      if (commit) begin
        bub_left[i] = 0; waiting[i] = 0; stalled[i] = 0;
        m_s[i] = 0; m_f[i] = 0; m_t[i] = 0;
      end
    end else begin
      fa = fwd_ref(rs1_e);
      fb = fwd_ref(rs2_e);
      if (waiting[i]) begin
        if (mem_ack) begin
          if (commit) waiting[i] = 0;
        end else if (stalled[i] == tmo[i] - 1) begin
          to = 1'b1;
          fe = 1'b1;
          if (commit) begin waiting[i] = 0; bub_left[i] = 0; end
        end else begin
          {sf, sd, se, sm} = 4'hf;
          if (commit) stalled[i]++;
        end
      end else if (mem_req && !mem_ack) begin
        {sf, sd, se, sm} = 4'hf;
        if (commit) begin waiting[i] = 1; stalled[i] = 1; end
      end else if (bub_left[i] > 0) begin
        sf = 1'b1; sd = 1'b1; fe = 1'b1;
        if (commit) bub_left[i]--;
      end else if (pc_src) begin
        fd = 1'b1; fe = 1'b1;
      end else if (lu) begin
        sf = 1'b1; sd = 1'b1; fe = 1'b1;
        if (commit) bub_left[i] = lub[i] - 1;
      end
      if (commit) begin
        if (sf)      m_s[i] = m_s[i] + 1;
        if (fd | fe) m_f[i] = m_f[i] + 1;
        if (to)      m_t[i] = m_t[i] + 1;
      end
    end
    o = {sf, sd, se, sm, fd, fe, fa, fb, to};
  endtask

  // Per-cycle compare of both instances against the model.
  task automatic settle();
    logic [10:0] e;
    logic [31:0] es, ef, et;
    #1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, 1'b0, e);
      check($sformatf("dut%0d_outputs", i), 32'(pack(i)), 32'(e));
`ifdef HAZARD_PERF_EN
      es = rst_n ? m_s[i] : 32'd0;
      ef = rst_n ? m_f[i] : 32'd0;
      et = rst_n ? m_t[i] : 32'd0;
`else
      es = 32'd0; ef = 32'd0; et = 32'd0;
`endif
      check($sformatf("dut%0d_perfStall", i), perf_s[i], es);
      check($sformatf("dut%0d_perfFlush", i), perf_f[i], ef);
      check($sformatf("dut%0d_perfTimeout", i), perf_t[i], et);
    end
  endtask

  task automatic advance();
    logic [10:0] e;
    for (int i = 0; i < 2; i++) model_step(i, 1'b1, e);
    @(negedge clk);
  endtask

  task automatic idle();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {mem_read_e, pc_src, rw_m, rw_w, mem_req, mem_ack} = '0;
  endtask

  task automatic lit(input string name, input int i, input logic [10:0] e);
    check(name, 32'(pack(i)), 32'(e));
  endtask

  initial begin
    idle();
    for (int i = 0; i < 2; i++) begin
      bub_left[i] = 0; waiting[i] = 0; stalled[i] = 0;
      m_s[i] = 0; m_f[i] = 0; m_t[i] = 0;
    end
    rs1_e = 5'd7; rd_m = 5'd7; rw_m = 1'b1;
    @(negedge clk);

    // Reset: only the flushes are active, forwarding suppressed.
    settle();
    lit("reset_outputs", 0, 11'h060);
    advance();
    rst_n = 1'b1;

    // Forwarding priority and x0 suppression.
    idle(); rd_m = 5'd7; rd_w = 5'd7; rw_m = 1'b1; rw_w = 1'b1; rs1_e = 5'd7;
    settle(); check("fwd_a_mem", 32'(fwd_a[0]), 32'd2); advance();
    rw_m = 1'b0;
    settle(); check("fwd_a_wb", 32'(fwd_a[0]), 32'd1); advance();
    idle(); rs2_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; rw_m = 1'b1; rw_w = 1'b1;
    settle(); check("fwd_b_x0", 32'(fwd_b[0]), 32'd0); advance();

    // Load-use: one bubble on dut0, two on dut1.
    idle(); mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    settle(); lit("lu1_c1", 0, 11'h620); lit("lu2_c1", 1, 11'h620); advance();
    idle();
    settle(); lit("lu1_c2", 0, 11'h000); lit("lu2_c2", 1, 11'h620); advance();
    settle(); lit("lu2_c3", 1, 11'h000); advance();

    // Redirect discards a simultaneous load-use.
    idle(); mem_read_e = 1'b1; rd_e = 5'd5; rs2_d = 5'd5; pc_src = 1'b1;
    settle(); lit("redir_c1", 0, 11'h060); lit("redir_c1_b", 1, 11'h060); advance();
    idle();
    settle(); lit("redir_c2", 0, 11'h000); lit("redir_c2_b", 1, 11'h000); advance();

    // Memory wait with ack on the 6th cycle.
    idle(); mem_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle(); lit($sformatf("wait_c%0d", k + 1), 0, 11'h780); advance();
    end
    mem_ack = 1'b1;
    settle(); lit("wait_ack", 0, 11'h000); advance();
    idle(); settle(); advance();

    // Wait entered from a pending bubble on dut1 resumes that bubble.
    idle(); mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    settle(); advance();
    idle(); mem_req = 1'b1;
    settle(); lit("luw_c1", 1, 11'h780); advance();
    settle(); lit("luw_c2", 1, 11'h780); advance();
    mem_ack = 1'b1;
    settle(); lit("luw_ack", 1, 11'h000); advance();
    idle();
    settle(); lit("luw_bubble", 1, 11'h620); advance();
    settle(); lit("luw_done", 1, 11'h000); advance();

    // Timeout on dut0 (MEM_TIMEOUT=8).
    idle(); mem_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      settle(); lit($sformatf("tmo_c%0d", k + 1), 0, 11'h780); advance();
    end
    settle(); lit("tmo_pulse", 0, 11'h021); advance();
    idle();
    settle(); lit("tmo_after", 0, 11'h000);
`ifdef HAZARD_PERF_EN
    check("tmo_perf", perf_t[0], 32'd1);
`else
    check("tmo_perf", perf_t[0], 32'd0);
`endif
    advance();

    // Asynchronous reset in the middle of a wait.
    idle(); mem_req = 1'b1;
    settle(); advance();
    settle(); advance();
    rst_n = 1'b0;
    settle(); lit("rst_wait0", 0, 11'h060); lit("rst_wait1", 1, 11'h060); advance();
    rst_n = 1'b1; idle();
    settle(); lit("rst_release", 0, 11'h000); advance();
    mem_read_e = 1'b1; rd_e = 5'd3; rs2_d = 5'd3;
    settle(); lit("rst_run0", 0, 11'h620); lit("rst_run1", 1, 11'h620); advance();
    idle(); settle(); advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      rs1_d      = W'($urandom_range(0, 3));
      rs2_d      = W'($urandom_range(0, 3));
      rs1_e      = W'($urandom_range(0, 3));
      rs2_e      = W'($urandom_range(0, 3));
      rd_e       = W'($urandom_range(0, 3));
      rd_m       = W'($urandom_range(0, 3));
      rd_w       = W'($urandom_range(0, 3));
      mem_read_e = ($urandom_range(0, 9) < 3);
      pc_src     = ($urandom_range(0, 9) < 2);
      rw_m       = ($urandom_range(0, 9) < 6);
      rw_w       = ($urandom_range(0, 9) < 6);
      mem_req    = ($urandom_range(0, 9) < 2);
      mem_ack    = waiting[0] ? ($urandom_range(0, 19) < 3) : ($urandom_range(0, 9) < 4);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
